// File: rtl/iob_ahb_manager.sv
// Purpose: converts the IOb valid/ready request interface into single AHB-Lite transfers.
//   The next address phase overlaps the current data phase.
// Latency: accept at edge N, address phase N+1, data phase N+2, rvalid/err pulse in cycle N+3.
// Backpressure: iob_ready drops while the A-stage is occupied and HREADY is low,
//   and during a two-cycle ERROR response.
// Ports:
//   HCLK, HRESET (sync, active-high)
//   iob_valid_i/iob_addr_i/iob_wdata_i/iob_wstrb_i/iob_ready_o  request side
//   iob_rvalid_o/iob_rdata_o/iob_err_o                           response side (one-cycle pulses)
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK/HWDATA      AHB manager outputs (registered)
//   HRDATA/HREADY/HRESP                                          AHB subordinate response
module iob_ahb_manager #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              iob_valid_i,
  input  logic [ADDR_W-1:0] iob_addr_i,
  input  logic [DATA_W-1:0] iob_wdata_i,
  input  logic [3:0]        iob_wstrb_i,
  output logic              iob_ready_o,
  output logic              iob_rvalid_o,
  output logic [DATA_W-1:0] iob_rdata_o,
  output logic              iob_err_o,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // A-stage: the request currently on HADDR/HTRANS (HADDR/HWRITE/HSIZE hold its control)
  logic              a_valid;
  logic              a_illegal;
  logic [DATA_W-1:0] a_wdata;
  // D-stage: the transfer in its data phase
  logic              d_valid;
  logic              d_write;
  logic              d_illegal;
  // Set between the two cycles of an ERROR response; blocks acceptance and idles the bus
  logic              err_hold;

  logic              accept;
  logic [2:0]        dec_size;
  logic [1:0]        dec_lo;
  logic              dec_illegal;

  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

  assign iob_ready_o = (~a_valid | HREADY) & ~err_hold;
  assign accept      = iob_valid_i & iob_ready_o;

  // Strobe pattern picks size and the low address bits; the IOb address low bits
  // are ignored except for illegal patterns, which keep the raw address for debug
  // (the bus never sees it since those entries drive IDLE).
  always_comb begin
    dec_size    = 3'b010;
    dec_lo      = 2'b00;
    dec_illegal = 1'b0;
    case (iob_wstrb_i)
      4'b0000, 4'b1111: begin
        dec_size = 3'b010;
        dec_lo   = 2'b00;
      end
      4'b0001: begin dec_size = 3'b000; dec_lo = 2'b00; end
      4'b0010: begin dec_size = 3'b000; dec_lo = 2'b01; end
      4'b0100: begin dec_size = 3'b000; dec_lo = 2'b10; end
      4'b1000: begin dec_size = 3'b000; dec_lo = 2'b11; end
      4'b0011: begin dec_size = 3'b001; dec_lo = 2'b00; end
      4'b1100: begin dec_size = 3'b001; dec_lo = 2'b10; end
      default: begin
        dec_illegal = 1'b1;
        dec_lo      = iob_addr_i[1:0];
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid      <= 1'b0;
      a_illegal    <= 1'b0;
      a_wdata      <= '0;
      d_valid      <= 1'b0;
      d_write      <= 1'b0;
      d_illegal    <= 1'b0;
      err_hold     <= 1'b0;
      HADDR        <= '0;
      HTRANS       <= TRANS_IDLE;
      HWRITE       <= 1'b0;
      HSIZE        <= 3'b000;
      HWDATA       <= '0;
      iob_rvalid_o <= 1'b0;
      iob_err_o    <= 1'b0;
      iob_rdata_o  <= '0;
    end else begin
      iob_rvalid_o <= 1'b0;
      iob_err_o    <= 1'b0;

      if (err_hold) begin
        // Second ERROR cycle: retire the D-stage with an error, then reissue the held request
        if (HREADY) begin
          if (d_valid) begin
            iob_rvalid_o <= ~d_write;
            iob_err_o    <= 1'b1;
            if (!d_write) iob_rdata_o <= HRDATA;
          end
          d_valid  <= 1'b0;
          err_hold <= 1'b0;
          HTRANS   <= (a_valid & ~a_illegal) ? TRANS_NONSEQ : TRANS_IDLE;
        end
      end else if (HREADY) begin
        if (d_valid) begin
          iob_rvalid_o <= ~d_write;
          iob_err_o    <= d_illegal | HRESP;
          if (!d_write) iob_rdata_o <= HRDATA;
        end
        d_valid   <= a_valid;
        d_write   <= HWRITE;
        d_illegal <= a_illegal;
        if (a_valid && HWRITE && !a_illegal) HWDATA <= a_wdata;
        a_valid <= 1'b0;
        HTRANS  <= TRANS_IDLE;
      end

      // A new request may load while HREADY is low only if the A-stage was empty
      if (accept) begin
        a_valid   <= 1'b1;
        a_illegal <= dec_illegal;
        a_wdata   <= iob_wdata_i;
        HADDR     <= {iob_addr_i[ADDR_W-1:2], dec_lo};
        HWRITE    <= |iob_wstrb_i;
        HSIZE     <= dec_size;
        HTRANS    <= dec_illegal ? TRANS_IDLE : TRANS_NONSEQ;
      end

      // First ERROR cycle: idle the bus next cycle, keep the A-stage request
      if (!err_hold && !HREADY && d_valid && HRESP) begin
        err_hold <= 1'b1;
        HTRANS   <= TRANS_IDLE;
      end
    end
  end

endmodule
